// File: rtl/wishbone_master_arbiter.sv
// Two-master Wishbone arbiter: fair tie-break on the last grant, grant held for a whole cyc.
// Optional stall timeout (err pulse to the granted master) enabled by macro WB_ARB_TIMEOUT_EN.
module wishbone_master_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_we_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic        m0_int_o,
   input  logic        m1_we_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        m1_int_o,
   output logic        s_we_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_int_i
);

   typedef struct packed {
      logic        we;
      logic        stb;
      logic        cyc;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } wb_req_t;

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   if (TIMEOUT == 8'd0) begin : g_bad_timeout
      $error("wishbone_master_arbiter: TIMEOUT must be in 1..255");
   end

   state_t  state, state_nxt;
   logic    last, last_nxt;
   wb_req_t req0, req1, gnt_req;

   assign req0 = '{we: m0_we_i, stb: m0_stb_i, cyc: m0_cyc_i,
                   sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
   assign req1 = '{we: m1_we_i, stb: m1_stb_i, cyc: m1_cyc_i,
                   sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   // A releasing master is never re-granted directly: it falls to the other master or IDLE.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      unique case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_nxt = GNT0;
            else if (m1_cyc_i)        state_nxt = GNT1;
            else                      state_nxt = IDLE;
         end
         GNT0: begin
            if (m0_cyc_i)      state_nxt = GNT0;
            else if (m1_cyc_i) state_nxt = GNT1;
            else               state_nxt = IDLE;
         end
         GNT1: begin
            if (m1_cyc_i)      state_nxt = GNT1;
            else if (m0_cyc_i) state_nxt = GNT0;
            else               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt == GNT0)      last_nxt = 1'b0;
      else if (state_nxt == GNT1) last_nxt = 1'b1;
   end

   always_comb begin
      gnt_req = '0;
      unique case (state)
         GNT0:    gnt_req = req0;
         GNT1:    gnt_req = req1;
         default: gnt_req = '0;
      endcase
   end

   assign s_we_o  = gnt_req.we;
   assign s_stb_o = gnt_req.stb;
   assign s_cyc_o = gnt_req.cyc;
   assign s_sel_o = gnt_req.sel;
   assign s_adr_o = gnt_req.adr;
   assign s_dat_o = gnt_req.dat;

   assign m0_ack_o = (state == GNT0) & s_ack_i;
   assign m1_ack_o = (state == GNT1) & s_ack_i;
   assign m0_dat_o = (state == GNT0) ? s_dat_i : 32'h0;
   assign m1_dat_o = (state == GNT1) ? s_dat_i : 32'h0;

   assign m0_int_o = s_int_i;
   assign m1_int_o = s_int_i;

`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0] to_cnt;
   logic       err_q;
   logic       err_m1;
   logic       stalled;
   logic       gnt_chg;

   assign stalled = s_stb_o & ~s_ack_i;
   assign gnt_chg = (state_nxt != state);

   // The stall that would bring the count to TIMEOUT clears it and raises a one-cycle
   // err on the next cycle, so a permanent stall errs once every TIMEOUT cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= 8'd0;
         err_q  <= 1'b0;
         err_m1 <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (!stalled || gnt_chg) begin
            to_cnt <= 8'd0;
         end else if (to_cnt == TIMEOUT - 8'd1) begin
            to_cnt <= 8'd0;
            err_q  <= 1'b1;
            err_m1 <= (state == GNT1);
         end else begin
            to_cnt <= to_cnt + 8'd1;
         end
      end
   end

   assign m0_err_o = err_q & ~err_m1;
   assign m1_err_o = err_q & err_m1;
`else
   assign m0_err_o = 1'b0;
   assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Bench for wishbone_master_arbiter: directed scenarios plus random traffic against a
// grant-owner reference model, compared on every falling edge.
module tb_wishbone_master_arbiter;

   localparam int TO = 4;
`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [31:0] A0 = 32'h0100_0004;
   localparam logic [31:0] A1 = 32'h0200_0008;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  cyc, stb, we;
   logic [3:0]  sel [2];
   logic [31:0] adr [2];
   logic [31:0] wdat [2];
   logic [31:0] s_dat_i;
   logic        s_ack_i, s_int_i;

   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_int_o, m1_int_o;
   logic        s_we_o, s_stb_o, s_cyc_o;
   logic [3:0]  s_sel_o;

   wishbone_master_arbiter #(.TIMEOUT(8'd4)) dut (
      .clk(clk), .rst(rst),
      .m0_we_i(we[0]), .m0_stb_i(stb[0]), .m0_cyc_i(cyc[0]), .m0_sel_i(sel[0]),
      .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o), .m0_int_o(m0_int_o),
      .m1_we_i(we[1]), .m1_stb_i(stb[1]), .m1_cyc_i(cyc[1]), .m1_sel_i(sel[1]),
      .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o), .m1_int_o(m1_int_o),
      .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_int_i(s_int_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model: who owns the bus (-1 = nobody), who won last, stall run length,
   // and which master (if any) is owed an err pulse this cycle.
   int owner = -1;
   int last  = 1;
   int stall = 0;
   int errp  = -1;

   function automatic int next_owner();
      if (owner < 0) begin
         if (cyc[0] && cyc[1]) return (last == 1) ? 0 : 1;
         if (cyc[0]) return 0;
         if (cyc[1]) return 1;
         return -1;
      end
      if (cyc[owner]) return owner;
      if (cyc[1 - owner]) return 1 - owner;
      return -1;
   endfunction

   function automatic bit stalled_now();
      return (owner >= 0) && stb[owner] && !s_ack_i;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         owner <= -1;
         last  <= 1;
         stall <= 0;
         errp  <= -1;
      end else begin
         owner <= next_owner();
         if (next_owner() >= 0) last <= next_owner();
         errp <= -1;
         if (!stalled_now() || next_owner() != owner) begin
            stall <= 0;
         end else if (stall + 1 == TO) begin
            stall <= 0;
            if (TO_EN) errp <= owner;
         end else begin
            stall <= stall + 1;
         end
      end
   end

   function automatic logic [140:0] exp_vec();
      logic [140:0] v;
      if (owner >= 0)
         v = {we[owner], stb[owner], cyc[owner], sel[owner], adr[owner], wdat[owner],
              (owner == 0) ? s_dat_i : 32'h0, (owner == 1) ? s_dat_i : 32'h0,
              (owner == 0) & s_ack_i, (owner == 1) & s_ack_i,
              errp == 0, errp == 1, s_int_i, s_int_i};
      else
         v = {3'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00,
              errp == 0, errp == 1, s_int_i, s_int_i};
      return v;
   endfunction

   wire [140:0] act_vec = {s_we_o, s_stb_o, s_cyc_o, s_sel_o, s_adr_o, s_dat_o,
                           m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
                           m0_err_o, m1_err_o, m0_int_o, m1_int_o};

   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_fail++;
            if (n_fail < 20)
               $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act_vec, exp_vec());
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cyc = 2'b00; stb = 2'b00; we = 2'b00;
      s_ack_i = 1'b0; s_int_i = 1'b0; s_dat_i = 32'h0;
      adr[0] = A0; adr[1] = A1;
      sel[0] = 4'hF; sel[1] = 4'h3;
      wdat[0] = 32'hAAAA_0000; wdat[1] = 32'hBBBB_1111;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   int pulses, m1p, e3, e4, g, waited;

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      chk("rst_s_cyc", {31'b0, s_cyc_o}, 32'h0);
      chk("rst_err", {30'b0, m0_err_o, m1_err_o}, 32'h0);
      chk("rst_model_owner", owner, -1);

      // Single m0 read, ack two cycles after grant
      cyc[0] = 1'b1; stb[0] = 1'b1;
      chk("lat_idle_cycle", {31'b0, s_cyc_o}, 32'h0);
      tick();
      chk("lat_n1_cyc", {31'b0, s_cyc_o}, 32'h1);
      chk("lat_n1_adr", s_adr_o, 32'h0100_0004);
      tick();
      chk("hold_adr", s_adr_o, 32'h0100_0004);
      s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("m0_ack", {31'b0, m0_ack_o}, 32'h1);
      chk("m0_dat", m0_dat_o, 32'hDEAD_BEEF);
      chk("m1_ack_quiet", {31'b0, m1_ack_o}, 32'h0);
      chk("m1_dat_quiet", m1_dat_o, 32'h0);
      tick();
      s_ack_i = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      tick();

      // Tie after reset: m0 first, m1 right after m0 releases
      do_reset();
      cyc = 2'b11; stb = 2'b11;
      tick();
      chk("tie_first_m0", s_adr_o, A0);
      chk("tie_model_owner", owner, 0);
      tick();
      cyc[0] = 1'b0; stb[0] = 1'b0;
      #1;
      chk("release_cycle_cyc", {31'b0, s_cyc_o}, 32'h0);
      tick();
      chk("handover_m1_adr", s_adr_o, A1);
      chk("handover_m1_cyc", {31'b0, s_cyc_o}, 32'h1);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      tick();

      // Four back-to-back contended transactions alternate m0, m1, m0, m1
      do_reset();
      cyc = 2'b11; stb = 2'b11;
      for (int t = 0; t < 4; t++) begin
         waited = 0;
         while (!s_cyc_o && waited < 10) begin
            tick();
            waited++;
         end
         if (waited >= 10) chk("b2b_grant_timeout", 32'(waited), 32'h0);
         g = (s_adr_o == A1) ? 1 : 0;
         chk($sformatf("b2b_order_%0d", t), g, t % 2);
         s_ack_i = 1'b1;
         tick();
         s_ack_i = 1'b0; cyc[g] = 1'b0; stb[g] = 1'b0;
         tick();
         cyc[g] = 1'b1; stb[g] = 1'b1;
      end
      cyc = 2'b00; stb = 2'b00;
      tick();
      tick();

      // m1 holds cyc across three beats while m0 waits
      do_reset();
      cyc[1] = 1'b1; stb[1] = 1'b1;
      tick();
      cyc[0] = 1'b1; stb[0] = 1'b1;
      for (int b = 0; b < 3; b++) begin
         s_ack_i = 1'b1; s_dat_i = 32'h1000 + 32'(b);
         #1;
         chk($sformatf("beat%0d_adr", b), s_adr_o, A1);
         chk($sformatf("beat%0d_m0_ack", b), {31'b0, m0_ack_o}, 32'h0);
         tick();
         s_ack_i = 1'b0; stb[1] = 1'b0;
         tick();
         stb[1] = 1'b1;
      end
      cyc[1] = 1'b0; stb[1] = 1'b0;
      #1;
      chk("m1_release_cycle", {31'b0, s_cyc_o}, 32'h0);
      tick();
      chk("m0_after_m1", s_adr_o, A0);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      tick();

      // Stalled m0 with no ack: err every TO cycles when enabled, never otherwise
      do_reset();
      cyc[0] = 1'b1; stb[0] = 1'b1;
      tick();
      pulses = 0; m1p = 0; e3 = 0; e4 = 0;
      for (int i = 0; i < 13; i++) begin
         pulses += int'(m0_err_o);
         m1p    += int'(m1_err_o);
         if (i == 3) e3 = int'(m0_err_o);
         if (i == 4) e4 = int'(m0_err_o);
         tick();
      end
      chk("to_pulse_count", pulses, TO_EN ? 3 : 0);
      chk("to_err_cycle4", e4, TO_EN ? 1 : 0);
      chk("to_err_cycle3", e3, 0);
      chk("to_m1_err", m1p, 0);
      chk("to_grant_kept", s_adr_o, A0);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      tick();

      // Reset during an m1 transfer
      do_reset();
      cyc[1] = 1'b1; stb[1] = 1'b1;
      tick();
      chk("pre_rst_cyc", {31'b0, s_cyc_o}, 32'h1);
      rst = 1'b1; s_ack_i = 1'b1;
      tick();
      chk("rst_mid_cyc", {31'b0, s_cyc_o}, 32'h0);
      chk("rst_mid_stb", {31'b0, s_stb_o}, 32'h0);
      chk("rst_mid_ack", {31'b0, m1_ack_o}, 32'h0);
      chk("rst_mid_err", {30'b0, m0_err_o, m1_err_o}, 32'h0);
      chk("rst_mid_model_idle", owner, -1);
      rst = 1'b0; s_ack_i = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
      tick();
      chk("post_rst_tie_m0", s_adr_o, A0);
      chk("post_rst_model_owner", owner, 0);

      // Random traffic checked cycle by cycle against the model
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         for (int m = 0; m < 2; m++) begin
            if ($urandom_range(0, 5) == 0) cyc[m] = ~cyc[m];
            stb[m]  = ($urandom_range(0, 3) != 0);
            we[m]   = 1'($urandom);
            sel[m]  = 4'($urandom);
            adr[m]  = $urandom;
            wdat[m] = $urandom;
         end
         s_ack_i = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         s_int_i = 1'($urandom);
         s_dat_i = $urandom;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
